// File: rtl/store_align_buffer.sv
// store_align_buffer: narrows sb/sh/sw register data into replicated byte
// lanes with byte enables, queues the result and drains it to data memory.
// Misaligned or reserved-size stores are consumed, flagged and dropped.
//
// Handshake: an input transfer happens on in_valid && in_ready, an output
// transfer on out_valid && out_ready. in_ready depends on occupancy only, so
// a full buffer refuses a store even if the head drains in the same cycle.
// out_* are registered state only; no in_* input reaches them in the same
// cycle. While out_valid && !out_ready the head entry is held stable.
module store_align_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_size,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_wdata,
  output logic [3:0]       out_be,
  output logic             misalign,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Entry storage (not reset: validity is tracked by pointers and count)
  logic [29:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  be_mem    [DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      misalign_addr_q, misalign_addr_d;

  logic [31:0] nar_wdata;
  logic [3:0]  nar_be;
  logic        nar_bad;
  logic        accept;
  logic        push;
  logic        pop;

  assign empty     = (count_q == '0);
  assign out_valid = !empty;
  assign in_ready  = (count_q < DEPTH_C);
  assign accept    = in_valid && in_ready;
  assign push      = accept && !nar_bad;
  assign pop       = out_valid && out_ready;

  assign count         = count_q;
  assign misalign      = misalign_q;
  assign misalign_addr = misalign_addr_q;

  // Lane replication, byte-enable generation and alignment check
  always_comb begin
    nar_wdata = in_data;
    nar_be    = 4'b1111;
    nar_bad   = 1'b0;
    case (in_size)
      2'b00: begin
        nar_wdata = {4{in_data[7:0]}};
        nar_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        nar_wdata = {2{in_data[15:0]}};
        nar_be    = in_addr[1] ? 4'b1100 : 4'b0011;
        nar_bad   = in_addr[0];
      end
      2'b10: begin
        nar_bad = (in_addr[1:0] != 2'b00);
      end
      default: begin
        nar_bad = 1'b1;
      end
    endcase
  end

  // Next-state for pointers, occupancy and the misalign flag
  always_comb begin
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    misalign_d      = accept && nar_bad;
    misalign_addr_d = misalign_addr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (accept && nar_bad) begin
      misalign_addr_d = in_addr;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      misalign_q      <= misalign_d;
      misalign_addr_q <= misalign_addr_d;
    end
  end

  // Write the narrowed store into the tail slot
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      addr_mem[wr_ptr_q]  <= in_addr[31:2];
      wdata_mem[wr_ptr_q] <= nar_wdata;
      be_mem[wr_ptr_q]    <= nar_be;
    end
  end

  // Head entry toward memory; zero while the buffer is empty
  always_comb begin
    out_addr  = '0;
    out_wdata = '0;
    out_be    = '0;
    if (out_valid) begin
      out_addr  = {addr_mem[rd_ptr_q], 2'b00};
      out_wdata = wdata_mem[rd_ptr_q];
      out_be    = be_mem[rd_ptr_q];
    end
  end

endmodule

// File: doc/store_align_buffer.md
Name: store_align_buffer

Overview:
- Store-side counterpart of the immediate/load widening path in the pipelined MIPS datapath.
- Takes 32-bit register data from the MEM stage for sb/sh/sw, narrows and replicates it into byte lanes, and generates byte enables from the address and size.
- Queues the result in a small FIFO and drains it to data memory over a valid/ready handshake.
- Flags misaligned stores and drops them.

Parameters:
- DEPTH, 2, number of buffered stores; must be a power of 2, >= 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  MEM stage presents a store.
- in_ready  output  1  buffer can take a store this cycle.
- in_addr  input  32  byte address.
- in_data  input  32  rt register value.
- in_size  input  2  store size: 00 = byte, 01 = half, 10 = word, 11 = reserved.
- out_valid  output  1  head entry valid toward data memory.
- out_ready  input  1  memory accepts the head entry.
- out_addr  output  32  word address {addr[31:2], 2'b00}.
- out_wdata  output  32  lane-replicated write data.
- out_be  output  4  byte enables, bit i = byte lane i (little-endian).
- misalign  output  1  one-cycle pulse: a store was dropped.
- misalign_addr  output  32  address of the last dropped store.
- count  output  CNT_W  current number of buffered entries.
- empty  output  1  count == 0.

Behaviour:
Reset:
- rst=1 at a clock edge clears the read pointer, write pointer and count to 0.
- out_valid=0, misalign=0, misalign_addr=0, empty=1.
- Reset takes priority over a push or pop in the same cycle.
- Reset mid-operation discards all queued entries; none are written to memory.

Handshake:
- Accept occurs on in_valid && in_ready.
- in_ready = (count < DEPTH). It is a function of state only and never depends on out_ready in the same cycle, so there is no full-bypass.
- Pop occurs on out_valid && out_ready.
- out_valid = !empty.
- While out_valid && !out_ready, out_addr, out_wdata and out_be hold stable.
- When empty, out_addr, out_wdata and out_be drive 0.

Latency:
- A store accepted at edge N is presented on out_* after edge N at the earliest, i.e. in the next cycle.
- There is no combinational path from the in_* inputs to the out_* outputs.

Narrowing (computed at accept, stored in the entry), with a = in_addr[1:0]:
- Byte: wdata = {4{in_data[7:0]}}, be = 4'b0001 << a.
- Half: wdata = {2{in_data[15:0]}}, be = a[1] ? 4'b1100 : 4'b0011.
- Word: wdata = in_data, be = 4'b1111.
- The stored address is {in_addr[31:2], 2'b00}.

Misalignment:
- A store is misaligned if: half with a[0]=1, word with a != 0, or in_size = 11.
- The store is consumed only when in_ready=1 and is not enqueued; count is unchanged.
- misalign=1 for exactly the cycle after the accept edge.
- misalign_addr loads the full in_addr and holds until the next misaligned store or reset.
- Back-to-back misaligned stores give back-to-back pulses.

Counter:
- Push only: +1. Pop only: -1. Push and pop in the same cycle: unchanged.
- Pointers wrap modulo DEPTH.
- When full, in_ready=0 even if out_ready=1 in that cycle.
- When empty, no pop occurs regardless of out_ready.
- Entries drain in FIFO order.

Test Plan:
- Byte store: in_addr=0x00001003, in_data=0x123456AB, size=00 -> next cycle out_valid=1, out_addr=0x00001000, out_wdata=0xABABABAB, out_be=1000; with out_ready=1 -> empty=1 the following cycle.
- Half store: in_addr=0x00002002, in_data=0x1234BEEF, size=01 -> out_wdata=0xBEEFBEEF, out_be=1100. Repeat at 0x00002000 -> out_be=0011.
- Misaligned word: in_addr=0x00003001, size=10 -> misalign pulses 1 cycle, misalign_addr=0x00003001, count stays 0, out_valid stays 0, in_ready stays 1.
- Backpressure, DEPTH=2: out_ready=0, three word stores to 0x10, 0x14, 0x18 offered back-to-back -> in_ready=0 after the second, count=2, outputs stable at 0x10; then out_ready=1 -> 0x10, 0x14, 0x18 drain in order, third accepted once count<2.
- Simultaneous push/pop: count=1, in_valid=1 and out_ready=1 in the same cycle -> count remains 1, new entry at head next cycle.
- Reset mid-operation: count=2, out_ready=0, assert rst for one edge -> next cycle out_valid=0, count=0, empty=1, in_ready=1, misalign=0.
